alarm_sequencer: RTL
====================

// Module: alarm_sequencer
// PURPOSE
//  Parametrised alarm tone sequencer, successor to the single-rate alarm toggler.
//  Drives a square-wave tone in bursts separated by silent gaps while the alarm
//  request (enable | WM) is high. Adds snooze, stop acknowledge and auto-timeout.
//  Sits between the time-compare/mode logic and the buzzer output pin.
// PARAMETERS
//  CNT_W          32    width of all cycle counters; every cycle parameter < 2**CNT_W
//  HALF_PERIOD    1000  clk cycles per tone half-period (>=1)
//  BEEPS_PER_BURST 4    full tone periods per burst (>=1)
//  GAP_CYCLES     50000 silent clk cycles between bursts (>=1)
//  SNOOZE_CYCLES  1000000 snooze length in clk cycles; 0 = snooze input ignored
//  TIMEOUT_BURSTS 60    completed bursts before auto-stop; 0 = never time out
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  reset      in   1  synchronous, active-high reset
//  enable     in   1  alarm time match (level)
//  WM         in   1  manual/test alarm request (level); request = enable | WM
//  snooze     in   1  one-cycle pulse: silence for SNOOZE_CYCLES then resume
//  stop       in   1  one-cycle pulse: silence until request drops
//  alarm_on   out  1  tone output (registered)
//  active     out  1  1 when state is BEEP or GAP (registered)
//  snoozing   out  1  1 when state is SNOOZE (registered)
//  timed_out  out  1  one-cycle pulse on auto-stop by timeout (registered)
// BEHAVIOUR
//  - reset: state=IDLE, ack=0, all counters 0, all outputs 0; reset beats all inputs.
//  - States IDLE, BEEP, GAP, SNOOZE. Internal flag ack set by stop/timeout.
//  - Priority per cycle (non-reset): request==0 > stop > snooze > normal sequencing.
//  - request==0 in any state: next cycle IDLE, alarm_on=0, counters 0, ack cleared.
//  - IDLE: if request && !ack -> BEEP next cycle with tone_cnt=0, toggles=0, alarm_on=0.
//  - BEEP: each cycle tone_cnt++; when tone_cnt==HALF_PERIOD-1: alarm_on toggles,
//    tone_cnt=0, toggles++. First rise after HALF_PERIOD BEEP cycles; burst lasts
//    exactly 2*HALF_PERIOD*BEEPS_PER_BURST cycles, ending with alarm_on=0.
//  - End of burst: bursts++; if TIMEOUT_BURSTS!=0 and bursts==TIMEOUT_BURSTS ->
//    IDLE, ack=1, timed_out=1 for one cycle; else -> GAP, gap_cnt=0.
//  - GAP: alarm_on=0; after GAP_CYCLES cycles -> BEEP (fresh burst, bursts kept).
//  - stop in BEEP/GAP/SNOOZE: next cycle IDLE, alarm_on=0, ack=1. stop in IDLE: ack=1
//    only if request high. ack holds silence until request==0 for >=1 cycle.
//  - snooze in BEEP/GAP (SNOOZE_CYCLES!=0): next cycle SNOOZE, alarm_on=0, bursts=0,
//    snz_cnt=0. snooze in SNOOZE or IDLE: ignored (no restart of snooze time).
//  - SNOOZE: after SNOOZE_CYCLES cycles -> BEEP fresh burst; stop still honoured.
//  - stop and snooze same cycle: stop wins. timeout and stop same cycle: timed_out=1.
//  - Counters compare with ==, never wrap in legal use; widths truncate to CNT_W.
//  - active/snoozing/alarm_on change on the same edge as the state register.
// TESTING  (bench params: HALF_PERIOD=4 BEEPS_PER_BURST=2 GAP_CYCLES=6
//           SNOOZE_CYCLES=20 TIMEOUT_BURSTS=3)
//  1 reset held 3 cycles with enable=1 -> alarm_on=active=snoozing=timed_out=0.
//  2 enable 0->1 -> active=1 next cycle; alarm_on rises 4 cycles later, toggles every
//    4, low after 16 BEEP cycles; 6 gap cycles low; second burst starts.
//  3 snooze mid-burst -> alarm_on=0, snoozing=1 for 20 cycles, then BEEP, first
//    rise 4 cycles later; bursts count restarts (3 more bursts before timeout).
//  4 enable held, no stop -> after 3rd burst timed_out pulses once, active=0, silent
//    while enable=1; drop enable 1 cycle and re-raise -> rings again.
//  5 stop and snooze same cycle -> IDLE, snoozing stays 0; WM alone rings like enable.
//  6 enable drops during SNOOZE -> IDLE next cycle; reset mid-BEEP -> all outputs 0.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm tone sequencer: square-wave bursts separated by silent gaps while the
// alarm request (enable | WM) is high, with snooze, stop acknowledge and
// auto-timeout after a configurable number of completed bursts.
module alarm_sequencer #(
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned HALF_PERIOD     = 1000,
    parameter int unsigned BEEPS_PER_BURST = 4,
    parameter int unsigned GAP_CYCLES      = 50000,
    parameter int unsigned SNOOZE_CYCLES   = 1000000,
    parameter int unsigned TIMEOUT_BURSTS  = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic WM,
    input  logic snooze,
    input  logic stop,
    output logic alarm_on,
    output logic active,
    output logic snoozing,
    output logic timed_out
);

    typedef enum logic [1:0] {StIdle, StBeep, StGap, StSnooze} state_e;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] TOGGLE_LAST = CNT_W'(2 * BEEPS_PER_BURST - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SNZ_LAST   = CNT_W'(SNOOZE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT   = CNT_W'(TIMEOUT_BURSTS);

    state_e           state;
    logic             ack;
    logic [CNT_W-1:0] tone_cnt;
    logic [CNT_W-1:0] toggles;
    logic [CNT_W-1:0] bursts;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] snz_cnt;

    logic request;
    logic half_done;
    logic burst_done;
    logic timeout_hit;
    logic snooze_ok;

    assign request    = enable | WM;
    assign half_done  = (tone_cnt == HALF_LAST);
    // The toggle that completes the burst is the one that returns the tone low.
    assign burst_done = half_done && (toggles == TOGGLE_LAST);
    assign timeout_hit = (TIMEOUT_BURSTS != 0) && ((bursts + ONE) == TO_LIMIT);
    assign snooze_ok  = (SNOOZE_CYCLES != 0) && ((state == StBeep) || (state == StGap));

    // State machine, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            ack       <= 1'b0;
            tone_cnt  <= '0;
            toggles   <= '0;
            bursts    <= '0;
            gap_cnt   <= '0;
            snz_cnt   <= '0;
            alarm_on  <= 1'b0;
            active    <= 1'b0;
            snoozing  <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            timed_out <= 1'b0;
            if (!request) begin
                state    <= StIdle;
                ack      <= 1'b0;
                tone_cnt <= '0;
                toggles  <= '0;
                bursts   <= '0;
                gap_cnt  <= '0;
                snz_cnt  <= '0;
                alarm_on <= 1'b0;
                active   <= 1'b0;
                snoozing <= 1'b0;
            end else if (stop) begin
                // A timeout landing on the same edge is still reported.
                if (state == StBeep && burst_done && timeout_hit) begin
                    timed_out <= 1'b1;
                end
                state    <= StIdle;
                ack      <= 1'b1;
                tone_cnt <= '0;
                toggles  <= '0;
                bursts   <= '0;
                gap_cnt  <= '0;
                snz_cnt  <= '0;
                alarm_on <= 1'b0;
                active   <= 1'b0;
                snoozing <= 1'b0;
            end else if (snooze && snooze_ok) begin
                state    <= StSnooze;
                bursts   <= '0;
                snz_cnt  <= '0;
                alarm_on <= 1'b0;
                active   <= 1'b0;
                snoozing <= 1'b1;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (!ack) begin
                            state    <= StBeep;
                            tone_cnt <= '0;
                            toggles  <= '0;
                            alarm_on <= 1'b0;
                            active   <= 1'b1;
                        end
                    end
                    StBeep: begin
                        if (half_done) begin
                            tone_cnt <= '0;
                            alarm_on <= ~alarm_on;
                            if (burst_done) begin
                                toggles <= '0;
                                bursts  <= bursts + ONE;
                                if (timeout_hit) begin
                                    state     <= StIdle;
                                    ack       <= 1'b1;
                                    active    <= 1'b0;
                                    timed_out <= 1'b1;
                                end else begin
                                    state   <= StGap;
                                    gap_cnt <= '0;
                                end
                            end else begin
                                toggles <= toggles + ONE;
                            end
                        end else begin
                            tone_cnt <= tone_cnt + ONE;
                        end
                    end
                    StGap: begin
                        alarm_on <= 1'b0;
                        if (gap_cnt == GAP_LAST) begin
                            state    <= StBeep;
                            gap_cnt  <= '0;
                            tone_cnt <= '0;
                            toggles  <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + ONE;
                        end
                    end
                    StSnooze: begin
                        alarm_on <= 1'b0;
                        if (snz_cnt == SNZ_LAST) begin
                            state    <= StBeep;
                            snz_cnt  <= '0;
                            tone_cnt <= '0;
                            toggles  <= '0;
                            active   <= 1'b1;
                            snoozing <= 1'b0;
                        end else begin
                            snz_cnt <= snz_cnt + ONE;
                        end
                    end
                    default: begin
                        state    <= StIdle;
                        alarm_on <= 1'b0;
                        active   <= 1'b0;
                        snoozing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
